riscv_fetch: RTL

Instruction fetch unit that produces the 32-bit instruction stream consumed by `riscv_decoder`. It owns the PC, issues in-order requests to instruction memory, buffers returned words in a small flushable FIFO, and presents them downstream through a valid/ready handshake. Control-flow redirects (JAL target, later branches) flush the stream and discard stale in-flight responses.

---
 rtl/riscv_fetch_pkg.sv | 15 +
 rtl/riscv_fetch_fifo.sv | 57 +++++
 rtl/riscv_fetch.sv | 111 +++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package riscv_fetch_pkg;

   typedef enum logic [1:0] {FS_BOOT, FS_RUN, FS_DRAIN} fetch_state_e;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered fetch result: the address it was fetched from plus the word.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small flushable FIFO holding {pc, instruction} pairs. Flush wins over push/pop.
module riscv_fetch_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [63:0]                push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [63:0]                head_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [63:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          push_ok;
   logic          pop_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign pop_ok    = pop && !empty;
   assign push_ok   = push && (!full || pop_ok);
   assign head_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a flush empties the FIFO in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage array; contents need no reset since count guards every read.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch: owns the PC, issues in-order imem requests under a credit
// limit, buffers tagged responses and streams them to the decoder.
// Handshakes: a transfer happens on a cycle where valid && ready are both high;
// a valid source holds its payload stable until that cycle. Responses have no
// ready and are always taken.
module riscv_fetch
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  resp_pc, resp_pc_nxt;   // address of the next live response
   logic [CW-1:0] outstanding, out_nxt;
   logic [CW-1:0] drop_cnt, drop_nxt;
   logic [CW-1:0] fifo_count;
   logic          fifo_empty;
   logic [63:0]   head_data;
   fetch_entry_t  head_e;
   logic          req_fire, resp_ok, push, pop;

   assign imem_req_valid = (state == FS_RUN) &&
                           (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
   assign imem_req_addr  = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;
   // A response with nothing outstanding is stale (e.g. from before reset).
   assign resp_ok        = imem_resp_valid && (outstanding != '0);
   assign push           = resp_ok && (state == FS_RUN) && !redirect_valid;
   assign pop            = inst_valid && inst_ready;
   assign out_nxt        = outstanding + CW'(req_fire) - CW'(resp_ok);

   assign head_e     = fetch_entry_t'(head_data);
   assign inst_valid = !fifo_empty;
   assign inst       = inst_valid ? head_e.data : INST_NOP;
   assign inst_pc    = inst_valid ? head_e.pc : 32'h0;

   riscv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({resp_pc, imem_resp_data}),
      .pop       (pop),
      .flush     (redirect_valid),
      .head_data (head_data),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   // State, PC and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FS_BOOT;
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         resp_pc     <= resp_pc_nxt;
         outstanding <= out_nxt;
         drop_cnt    <= drop_nxt;
      end
   end

   // Next-state logic; a redirect overrides everything and counts the
   // requests still in flight after this cycle as words to discard.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      resp_pc_nxt = resp_pc;
      drop_nxt    = drop_cnt;
      if (req_fire) pc_nxt = pc + 32'd4;
      if (push)     resp_pc_nxt = resp_pc + 32'd4;
      case (state)
         FS_BOOT:  state_nxt = FS_RUN;
         FS_RUN:   state_nxt = FS_RUN;
         FS_DRAIN: begin
            if (resp_ok) begin
               drop_nxt = drop_cnt - CW'(1);
               if (drop_cnt == CW'(1)) state_nxt = FS_RUN;
            end
         end
         default:  state_nxt = FS_BOOT;
      endcase
      if (redirect_valid) begin
         pc_nxt      = redirect_pc & 32'hFFFF_FFFC;
         resp_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
         drop_nxt    = out_nxt;
         state_nxt   = (out_nxt != '0) ? FS_DRAIN : FS_RUN;
      end
   end

endmodule
